// File: rtl/lut_mult_pkg.sv
// ============================================================================
//  lut_mult_pkg
//  Shared state encoding and width helper for the iterative LUT multiplier.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package lut_mult_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Ceiling log2; the caller clamps to a minimum of one bit.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lut_pp_radix4.sv
// ============================================================================
//  lut_pp_radix4
//  Radix-4 partial-product lookup: pp = a * sel for sel in {0,1,2,3}.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module lut_pp_radix4 #(
    parameter int WIDTH_A = 4
) (
    input  logic [WIDTH_A-1:0] a,
    input  logic [1:0]         sel,
    output logic [WIDTH_A+1:0] pp
);

    always_comb begin
        pp = '0;
        case (sel)
            2'd0:    pp = '0;
            2'd1:    pp = {2'b00, a};
            2'd2:    pp = {1'b0, a, 1'b0};
            2'd3:    pp = {2'b00, a} + {1'b0, a, 1'b0};
            default: pp = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/lut_multiplier_seq.sv
// ============================================================================
//  lut_multiplier_seq
//  Iterative unsigned multiplier retiring two bits of B per clock.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module lut_multiplier_seq
    import lut_mult_pkg::*;
#(
    parameter int WIDTH_A    = 4,
    parameter int WIDTH_B    = 8,
    parameter int EARLY_EXIT = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [WIDTH_A-1:0]         A,
    input  logic [WIDTH_B-1:0]         B,
    output logic [WIDTH_A+WIDTH_B-1:0] M,
    output logic                       done,
    output logic                       busy
);

    localparam int C_N  = WIDTH_B / 2;
    localparam int C_PW = WIDTH_A + WIDTH_B;
    localparam int C_SW = (clog2(C_N) < 1) ? 1 : clog2(C_N);
    localparam logic [C_SW-1:0] C_LAST = C_SW'(C_N - 1);

    state_t              r_state;
    state_t              w_state_next;
    logic [WIDTH_A-1:0]  r_a;
    logic [WIDTH_B-1:0]  r_b_sh;
    logic [WIDTH_B-1:0]  w_b_rest;
    logic [C_SW-1:0]     r_step;
    logic [C_PW-1:0]     r_acc;
    logic [C_PW-1:0]     w_acc_next;
    logic [C_PW-1:0]     w_pp_shifted;
    logic [WIDTH_A+1:0]  w_pp;
    logic [C_PW-1:0]     r_m;
    logic                r_done;
    logic                r_busy;
    logic                w_last;
    logic                w_accept;
    logic                w_finish;

    lut_pp_radix4 #(
        .WIDTH_A (WIDTH_A)
    ) u_pp (
        .a   (r_a),
        .sel (r_b_sh[1:0]),
        .pp  (w_pp)
    );

    assign w_pp_shifted = C_PW'(w_pp) << {r_step, 1'b0};
    assign w_acc_next   = r_acc + w_pp_shifted;
    assign w_b_rest     = r_b_sh >> 2;
    // Early exit looks at the digits still waiting after the current one.
    assign w_last       = (r_step == C_LAST) || ((EARLY_EXIT != 0) && (w_b_rest == '0));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_finish     = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a    <= '0;
            r_b_sh <= '0;
            r_step <= '0;
            r_acc  <= '0;
            r_m    <= '0;
            r_done <= 1'b0;
            r_busy <= 1'b0;
        end else begin
            r_done <= w_finish;
            if (w_accept) begin
                r_a    <= A;
                r_b_sh <= B;
                r_step <= '0;
                r_acc  <= '0;
                r_busy <= 1'b1;
            end else if (r_state == ST_RUN) begin
                r_acc  <= w_acc_next;
                r_b_sh <= w_b_rest;
                r_step <= r_step + 1'b1;
                if (w_finish) begin
                    r_m    <= w_acc_next;
                    r_busy <= 1'b0;
                end
            end
        end
    end

    assign M    = r_m;
    assign done = r_done;
    assign busy = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_lut_multiplier_seq.sv
// ============================================================================
//  tb_lut_multiplier_seq
//  Self-checking bench: four configurations checked against M == A*B.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_lut_multiplier_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  start_v;
    logic [7:0]  a_bus;
    logic [11:0] b_bus;
    logic [3:0]  done_v;
    logic [3:0]  busy_v;
    logic [11:0] m_d;
    logic [11:0] m_e;
    logic [7:0]  m_s;
    logic [19:0] m_w;
    logic [19:0] m_v [4];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // 0: default, 1: early exit, 2: 4x4 sweep, 3: 8x12 wide
    lut_multiplier_seq #(.WIDTH_A(4), .WIDTH_B(8), .EARLY_EXIT(0)) dut (
        .clk(clk), .reset(reset), .start(start_v[0]), .A(a_bus[3:0]), .B(b_bus[7:0]),
        .M(m_d), .done(done_v[0]), .busy(busy_v[0]));
    lut_multiplier_seq #(.WIDTH_A(4), .WIDTH_B(8), .EARLY_EXIT(1)) dut_ee (
        .clk(clk), .reset(reset), .start(start_v[1]), .A(a_bus[3:0]), .B(b_bus[7:0]),
        .M(m_e), .done(done_v[1]), .busy(busy_v[1]));
    lut_multiplier_seq #(.WIDTH_A(4), .WIDTH_B(4), .EARLY_EXIT(0)) dut_sw (
        .clk(clk), .reset(reset), .start(start_v[2]), .A(a_bus[3:0]), .B(b_bus[3:0]),
        .M(m_s), .done(done_v[2]), .busy(busy_v[2]));
    lut_multiplier_seq #(.WIDTH_A(8), .WIDTH_B(12), .EARLY_EXIT(0)) dut_wd (
        .clk(clk), .reset(reset), .start(start_v[3]), .A(a_bus), .B(b_bus),
        .M(m_w), .done(done_v[3]), .busy(busy_v[3]));

    assign m_v[0] = {8'd0, m_d};
    assign m_v[1] = {8'd0, m_e};
    assign m_v[2] = {12'd0, m_s};
    assign m_v[3] = m_w;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Launch one product on instance sel and wait (bounded) for its done pulse.
    task automatic op(input int sel, input logic [7:0] a_in, input logic [11:0] b_in,
                      output int lat, output logic [19:0] m_out);
        a_bus = a_in;
        b_bus = b_in;
        start_v[sel] = 1'b1;
        tick;
        start_v[sel] = 1'b0;
        a_bus = 8'($urandom);
        b_bus = 12'($urandom);
        lat   = -1;
        m_out = 'x;
        for (int i = 1; i <= 12; i++) begin
            tick;
            if (done_v[sel]) begin
                lat   = i;
                m_out = m_v[sel];
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset   = 1'b1;
        start_v = '0;
        a_bus   = '0;
        b_bus   = '0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (m_d !== 12'd0) begin n_errors++; $display("FAIL reset_m actual=%0d required=0", m_d); end
        n_checks++; if (done_v !== 4'd0) begin n_errors++; $display("FAIL reset_done actual=%b required=0000", done_v); end
        n_checks++; if (busy_v !== 4'd0) begin n_errors++; $display("FAIL reset_busy actual=%b required=0000", busy_v); end
        reset = 1'b0;
        tick;
    endtask

    task automatic test_basic;
        a_bus = 8'd15;
        b_bus = 12'd255;
        start_v[0] = 1'b1;
        tick;
        start_v[0] = 1'b0;
        a_bus = '0;
        b_bus = '0;
        n_checks++; if (busy_v[0] !== 1'b1) begin n_errors++; $display("FAIL basic_busy_accept actual=%b required=1", busy_v[0]); end
        for (int i = 1; i <= 4; i++) begin
            tick;
            n_checks++; if (done_v[0] !== 1'(i == 4)) begin n_errors++; $display("FAIL basic_done cyc=%0d actual=%b required=%b", i, done_v[0], i == 4); end
            n_checks++; if (busy_v[0] !== 1'(i < 4)) begin n_errors++; $display("FAIL basic_busy cyc=%0d actual=%b required=%b", i, busy_v[0], i < 4); end
        end
        n_checks++; if (m_d !== 12'd3825) begin n_errors++; $display("FAIL basic_m actual=%0d required=3825", m_d); end
        repeat (2) tick;
        n_checks++; if (done_v[0] !== 1'b0) begin n_errors++; $display("FAIL basic_done_pulse actual=%b required=0", done_v[0]); end
        n_checks++; if (m_d !== 12'd3825) begin n_errors++; $display("FAIL basic_m_hold actual=%0d required=3825", m_d); end
    endtask

    task automatic test_early_exit;
        int lat;
        int steps;
        logic [19:0] m;
        logic [7:0] a_r;
        logic [7:0] b_r;
        logic [7:0] a_tab [3] = '{8'd9, 8'd9, 8'd9};
        logic [7:0] b_tab [3] = '{8'h00, 8'h03, 8'hC0};
        int lat_tab [3] = '{1, 1, 4};
        for (int k = 0; k < 3; k++) begin
            op(1, a_tab[k], 12'(b_tab[k]), lat, m);
            n_checks++; if (lat !== lat_tab[k]) begin n_errors++; $display("FAIL ee_lat b=%h actual=%0d required=%0d", b_tab[k], lat, lat_tab[k]); end
            n_checks++; if (m !== 20'(a_tab[k]) * 20'(b_tab[k])) begin n_errors++; $display("FAIL ee_m b=%h actual=%0d required=%0d", b_tab[k], m, a_tab[k] * b_tab[k]); end
        end
        for (int k = 0; k < 40; k++) begin
            a_r = 8'($urandom_range(0, 15));
            b_r = 8'($urandom);
            // Radix-4 digits needed to represent B, at least one.
            steps = 1;
            for (int d = 1; d < 4; d++) if ((b_r >> (2 * d)) != 0) steps = d + 1;
            op(1, a_r, 12'(b_r), lat, m);
            n_checks++; if (lat !== steps) begin n_errors++; $display("FAIL ee_rand_lat b=%h actual=%0d required=%0d", b_r, lat, steps); end
            n_checks++; if (m !== 20'(a_r) * 20'(b_r)) begin n_errors++; $display("FAIL ee_rand_m a=%0d b=%0d actual=%0d required=%0d", a_r, b_r, m, a_r * b_r); end
        end
    endtask

    task automatic test_ignore;
        int lat;
        int extra;
        a_bus = 8'd3;
        b_bus = 12'd5;
        start_v[0] = 1'b1;
        tick;
        start_v[0] = 1'b0;
        tick;
        a_bus = 8'd7;
        b_bus = 12'd7;
        start_v[0] = 1'b1;
        tick;
        start_v[0] = 1'b0;
        lat = -1;
        for (int i = 3; i <= 12; i++) begin
            tick;
            if (done_v[0]) begin
                lat = i;
                break;
            end
        end
        n_checks++; if (lat !== 4) begin n_errors++; $display("FAIL ignore_lat actual=%0d required=4", lat); end
        n_checks++; if (m_d !== 12'd15) begin n_errors++; $display("FAIL ignore_m actual=%0d required=15", m_d); end
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            tick;
            if (done_v[0] || busy_v[0]) extra++;
        end
        n_checks++; if (extra !== 0) begin n_errors++; $display("FAIL ignore_not_queued actual=%0d required=0", extra); end
    endtask

    task automatic test_reset_mid;
        int lat;
        int extra;
        logic [19:0] m;
        a_bus = 8'd15;
        b_bus = 12'd255;
        start_v[0] = 1'b1;
        tick;
        start_v[0] = 1'b0;
        tick;
        #2 reset = 1'b1;
        #1;
        n_checks++; if (m_d !== 12'd0) begin n_errors++; $display("FAIL midreset_m actual=%0d required=0", m_d); end
        n_checks++; if (busy_v[0] !== 1'b0) begin n_errors++; $display("FAIL midreset_busy actual=%b required=0", busy_v[0]); end
        n_checks++; if (done_v[0] !== 1'b0) begin n_errors++; $display("FAIL midreset_done actual=%b required=0", done_v[0]); end
        #1 reset = 1'b0;
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            tick;
            if (done_v[0] || busy_v[0]) extra++;
        end
        n_checks++; if (extra !== 0) begin n_errors++; $display("FAIL midreset_no_done actual=%0d required=0", extra); end
        op(0, 8'd6, 12'd11, lat, m);
        n_checks++; if (lat !== 4) begin n_errors++; $display("FAIL midreset_next_lat actual=%0d required=4", lat); end
        n_checks++; if (m !== 20'd66) begin n_errors++; $display("FAIL midreset_next_m actual=%0d required=66", m); end
    endtask

    task automatic test_back_to_back;
        int lat;
        a_bus = 8'd2;
        b_bus = 12'd3;
        start_v[0] = 1'b1;
        tick;
        a_bus = 8'd5;
        b_bus = 12'd6;
        for (int i = 1; i <= 4; i++) tick;
        n_checks++; if (done_v[0] !== 1'b1) begin n_errors++; $display("FAIL b2b_first_done actual=%b required=1", done_v[0]); end
        n_checks++; if (m_d !== 12'd6) begin n_errors++; $display("FAIL b2b_first_m actual=%0d required=6", m_d); end
        tick;
        start_v[0] = 1'b0;
        a_bus = '0;
        b_bus = '0;
        n_checks++; if (busy_v[0] !== 1'b1) begin n_errors++; $display("FAIL b2b_second_accept actual=%b required=1", busy_v[0]); end
        n_checks++; if (m_d !== 12'd6) begin n_errors++; $display("FAIL b2b_m_undisturbed actual=%0d required=6", m_d); end
        lat = -1;
        for (int i = 1; i <= 12; i++) begin
            tick;
            if (done_v[0]) begin
                lat = i;
                break;
            end
        end
        n_checks++; if (lat !== 4) begin n_errors++; $display("FAIL b2b_second_lat actual=%0d required=4", lat); end
        n_checks++; if (m_d !== 12'd30) begin n_errors++; $display("FAIL b2b_second_m actual=%0d required=30", m_d); end
    endtask

    task automatic test_sweep;
        int lat;
        logic [19:0] m;
        logic [7:0] a_r;
        logic [11:0] b_r;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                op(2, 8'(a), 12'(b), lat, m);
                n_checks++; if (lat !== 2) begin n_errors++; $display("FAIL sweep_lat a=%0d b=%0d actual=%0d required=2", a, b, lat); end
                n_checks++; if (m !== 20'(a * b)) begin n_errors++; $display("FAIL sweep_m a=%0d b=%0d actual=%0d required=%0d", a, b, m, a * b); end
            end
        end
        for (int k = 0; k < 2000; k++) begin
            a_r = 8'($urandom);
            b_r = 12'($urandom);
            if (k == 0) begin a_r = 8'hFF; b_r = 12'hFFF; end
            op(3, a_r, b_r, lat, m);
            n_checks++; if (lat !== 6) begin n_errors++; $display("FAIL wide_lat a=%0d b=%0d actual=%0d required=6", a_r, b_r, lat); end
            n_checks++; if (m !== 20'(a_r) * 20'(b_r)) begin n_errors++; $display("FAIL wide_m a=%0d b=%0d actual=%0d required=%0d", a_r, b_r, m, 20'(a_r) * 20'(b_r)); end
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_early_exit;
        test_ignore;
        test_reset_mid;
        test_back_to_back;
        test_sweep;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
